// File: rtl/dmem_host_ctrl.sv
// Host-side sequencer for a core's data memory: streams words in, starts the core,
// waits for completion, then streams a window of data memory back out.
module dmem_host_ctrl #(
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter int unsigned LOAD_LEN  = 16,
  parameter logic [15:0] DUMP_BASE = 16'h0100,
  parameter int unsigned DUMP_LEN  = 16
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        go,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        END,
  input  logic [15:0] dmem_out_disp,
  output logic        START,
  output logic [1:0]  addr_mux_select,
  output logic [15:0] current_addr,
  output logic [15:0] ar_in,
  output logic        write_from_tb,
  output logic [15:0] mem_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LEN);
  localparam logic [CNT_W-1:0] DUMP_CNT = CNT_W'(DUMP_LEN);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hs_in;
  logic             hs_out;

  assign cnt_inc = cnt + CNT_W'(1);
  assign hs_in   = (state == LOAD) && in_valid;
  assign hs_out  = (state == DUMP_OUT) && out_ready;

  // The memory write strobe and data follow the handshake within the same cycle.
  assign write_from_tb = hs_in;
  assign mem_data      = hs_in ? in_data : 16'h0000;

  // Next-state logic; END is disregarded while START is still high.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (go) state_n = (LOAD_CNT == '0) ? RUN : LOAD;
      LOAD:       if (hs_in && (cnt_inc == LOAD_CNT)) state_n = RUN;
      RUN:        if (END && !START) state_n = (DUMP_CNT == '0) ? DONE : DUMP_ADDR;
      DUMP_ADDR:  state_n = DUMP_WAIT;
      DUMP_WAIT:  state_n = DUMP_OUT;
      DUMP_OUT:   if (out_ready) state_n = (cnt_inc < DUMP_CNT) ? DUMP_ADDR : DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= IDLE;
      cnt             <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= 16'h0000;
      START           <= 1'b0;
      addr_mux_select <= 2'd0;
      current_addr    <= 16'h0000;
      ar_in           <= 16'h0000;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == LOAD);
      out_valid <= (state_n == DUMP_OUT);
      START     <= (state_n == RUN) && (state != RUN);
      busy      <= (state_n != IDLE) && (state_n != DONE);
      done      <= (state_n == DONE);

      case (state_n)
        LOAD:      addr_mux_select <= 2'd1;
        DUMP_ADDR: addr_mux_select <= 2'd2;
        default:   addr_mux_select <= 2'd0;
      endcase

      // One counter serves both phases: it is cleared whenever neither stream is active.
      if (hs_in || hs_out) begin
        cnt <= cnt_inc;
      end else if ((state == IDLE) || (state == RUN) || (state == DONE)) begin
        cnt <= '0;
      end

      if ((state_n == LOAD) && (state != LOAD)) begin
        current_addr <= LOAD_BASE;
      end else if (hs_in) begin
        current_addr <= current_addr + 16'd1;
      end

      if ((state == RUN) && (state_n == DUMP_ADDR)) begin
        ar_in <= DUMP_BASE;
      end else if (hs_out) begin
        ar_in <= ar_in + 16'd1;
      end

      if (state == DUMP_WAIT) begin
        out_data <= dmem_out_disp;
      end
    end
  end

endmodule

// File: tb/tb_dmem_host_ctrl.sv
// Randomized self-checking bench for dmem_host_ctrl: a wrapping load/dump configuration
// plus a zero-length configuration, checked against a simple memory reference model.
module tb_dmem_host_ctrl;

  localparam logic [15:0] LB = 16'hFFFE;
  localparam int unsigned LL = 4;
  localparam logic [15:0] DB = 16'hFFFF;
  localparam int unsigned DL = 3;

  logic        clk;
  logic        rst_n;
  logic        go, in_valid, in_ready, out_valid, out_ready, end_in, start;
  logic        write_from_tb, busy, done;
  logic [15:0] in_data, out_data, dmem_out_disp, current_addr, ar_in, mem_data;
  logic [1:0]  addr_mux_select;

  logic        go0, in_valid0, in_ready0, out_valid0, out_ready0, end0, start0;
  logic        write0, busy0, done0;
  logic [15:0] in_data0, out_data0, dmem0, current_addr0, ar_in0, mem_data0;
  logic [1:0]  sel0;

  dmem_host_ctrl #(.LOAD_BASE(LB), .LOAD_LEN(LL), .DUMP_BASE(DB), .DUMP_LEN(DL)) dut (
    .clk(clk), .RESET_N(rst_n), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .END(end_in), .dmem_out_disp(dmem_out_disp), .START(start),
    .addr_mux_select(addr_mux_select), .current_addr(current_addr), .ar_in(ar_in),
    .write_from_tb(write_from_tb), .mem_data(mem_data), .busy(busy), .done(done)
  );

  dmem_host_ctrl #(.LOAD_BASE(16'h1234), .LOAD_LEN(0), .DUMP_BASE(16'h0100), .DUMP_LEN(0)) dut0 (
    .clk(clk), .RESET_N(rst_n), .go(go0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .END(end0), .dmem_out_disp(dmem0), .START(start0),
    .addr_mux_select(sel0), .current_addr(current_addr0), .ar_in(ar_in0),
    .write_from_tb(write0), .mem_data(mem_data0), .busy(busy0), .done(done0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_base = 0;
  int bad0 = 0;
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_d[$];
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the controller: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (write_from_tb) mem[current_addr] <= mem_data;
    case (addr_mux_select)
      2'd1:    dmem_out_disp <= mem[current_addr];
      2'd2:    dmem_out_disp <= mem[ar_in];
      default: dmem_out_disp <= mem[16'h0000];
    endcase
  end

  always @(negedge clk) begin
    if (write_from_tb) begin
      wa_q.push_back(current_addr);
      wd_q.push_back(mem_data);
    end
    if (start) start_cnt++;
    if (write0 || out_valid0) bad0++;
  end

  task automatic test_reset();
    rst_n = 1'b0; go = 0; in_valid = 1; in_data = 16'hABCD; out_ready = 0; end_in = 0;
    go0 = 0; in_valid0 = 0; in_data0 = 16'h0; out_ready0 = 0; end0 = 0; dmem0 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, start, write_from_tb, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {in_ready, out_valid, start, write_from_tb, busy, done});
    end
    checks++;
    if (addr_mux_select !== 2'd0) begin
      errors++; $display("FAIL reset_sel: got %0d expected 0", addr_mux_select);
    end
    checks++;
    if ({current_addr, ar_in, mem_data, out_data} !== 64'h0) begin
      errors++; $display("FAIL reset_buses: got %h expected 0",
                         {current_addr, ar_in, mem_data, out_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: in_ready=%b busy=%b expected 0 0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [15:0] w;
    wa_q.delete(); wd_q.delete(); exp_a.delete(); exp_d.delete();
    start_base = start_cnt;
    go = 1; @(posedge clk); #1; go = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || current_addr !== LB || addr_mux_select !== 2'd1) begin
      errors++; $display("FAIL load_entry: in_ready=%b addr=%h sel=%0d expected 1 %h 1",
                         in_ready, current_addr, addr_mux_select, LB);
    end
    @(posedge clk); #1;
    for (int k = 0; k < int'(LL); k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 0; in_data = 16'(($urandom));
        @(negedge clk);
        checks++;
        if (write_from_tb !== 1'b0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL load_gap: write=%b in_ready=%b expected 0 1", write_from_tb, in_ready);
        end
        @(posedge clk); #1;
      end
      w = 16'($urandom);
      in_valid = 1; in_data = w;
      exp_a.push_back(16'(LB + k));
      exp_d.push_back(w);
      ref_mem[16'(LB + k)] = w;
      @(negedge clk);
      checks++;
      if (write_from_tb !== 1'b1 || current_addr !== 16'(LB + k) || mem_data !== w) begin
        errors++; $display("FAIL load_word%0d: write=%b addr=%h data=%h expected 1 %h %h",
                           k, write_from_tb, current_addr, mem_data, 16'(LB + k), w);
      end
      @(posedge clk); #1;
      in_valid = 0;
    end
    checks++;
    if (wa_q.size() != exp_a.size()) begin
      errors++; $display("FAIL load_count: got %0d writes expected %0d", wa_q.size(), exp_a.size());
    end else begin
      for (int k = 0; k < exp_a.size(); k++) begin
        checks++;
        if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin
          errors++; $display("FAIL load_log%0d: got %h:%h expected %h:%h",
                             k, wa_q[k], wd_q[k], exp_a[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_run(input bit end_early);
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || addr_mux_select !== 2'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL start_cycle: start=%b sel=%0d busy=%b in_ready=%b expected 1 0 1 0",
                         start, addr_mux_select, busy, in_ready);
    end
    if (end_early) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (start !== 1'b0 || addr_mux_select !== 2'd0 || busy !== 1'b1) begin
        errors++; $display("FAIL end_ignored: start=%b sel=%0d busy=%b expected 0 0 1",
                           start, addr_mux_select, busy);
      end
    end else begin
      for (int i = $urandom_range(1, 4); i > 0; i--) begin
        @(posedge clk); #1;
        go = (i % 2 == 1);
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || addr_mux_select !== 2'd0 || busy !== 1'b1) begin
          errors++; $display("FAIL run_wait: start=%b sel=%0d busy=%b expected 0 0 1",
                             start, addr_mux_select, busy);
        end
      end
      go = 0;
      end_in = 1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (addr_mux_select !== 2'd2 || ar_in !== DB) begin
      errors++; $display("FAIL dump_addr: sel=%0d ar_in=%h expected 2 %h", addr_mux_select, ar_in, DB);
    end
    checks++;
    if (start_cnt !== start_base + 1) begin
      errors++; $display("FAIL start_once: got %0d pulses expected 1", start_cnt - start_base);
    end
    end_in = 0;
  endtask

  task automatic test_dump(input bit stall);
    logic [15:0] exp;
    logic [15:0] held;
    int hs[3];
    int cyc_w;
    for (int j = 0; j < int'(DL); j++) begin
      exp = ref_mem[16'(DB + j)];
      out_ready = (stall && j == 1) ? 1'b0 : 1'b1;
      cyc_w = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && cyc_w < 8) begin
        cyc_w++;
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL dump_word%0d: valid=%b data=%h expected 1 %h", j, out_valid, out_data, exp);
      end
      if (stall && j == 1) begin
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            errors++; $display("FAIL stall_hold: valid=%b data=%h expected 1 %h", out_valid, out_data, held);
          end
        end
        out_ready = 1'b1;
      end
      hs[j] = cyc;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || addr_mux_select !== 2'd0) begin
      errors++; $display("FAIL dump_done: done=%b busy=%b valid=%b sel=%0d expected 1 0 0 0",
                         done, busy, out_valid, addr_mux_select);
    end
    checks++;
    if (hs[2] - hs[1] !== 3) begin
      errors++; $display("FAIL throughput_b: got %0d cycles expected 3", hs[2] - hs[1]);
    end
    if (!stall) begin
      checks++;
      if (hs[1] - hs[0] !== 3) begin
        errors++; $display("FAIL throughput_a: got %0d cycles expected 3", hs[1] - hs[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w;
    int nw0;
    int sc;
    nw0 = wa_q.size();
    sc = start_cnt;
    go = 1; @(posedge clk); #1; go = 0;
    for (int k = 0; k < 2; k++) begin
      w = 16'($urandom);
      in_valid = 1; in_data = w;
      ref_mem[16'(LB + k)] = w;
      @(posedge clk); #1;
    end
    in_data = 16'($urandom);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, write_from_tb, busy, start} !== 4'b0 || current_addr !== 16'h0 || mem_data !== 16'h0) begin
      errors++; $display("FAIL async_reset: flags=%b addr=%h data=%h expected 0 0 0",
                         {in_ready, write_from_tb, busy, start}, current_addr, mem_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || write_from_tb !== 1'b0 || start !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: in_ready=%b write=%b start=%b expected 0 0 0",
                           in_ready, write_from_tb, start);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (wa_q.size() !== nw0 + 2 || start_cnt !== sc) begin
      errors++; $display("FAIL abort_effects: writes=%0d starts=%0d expected 2 0",
                         wa_q.size() - nw0, start_cnt - sc);
    end
    in_valid = 0;
  endtask

  task automatic test_zero_len();
    int b;
    b = bad0;
    in_valid0 = 1; in_data0 = 16'h5A5A; out_ready0 = 1; end0 = 1;
    go0 = 1; @(posedge clk); #1; go0 = 0;
    @(negedge clk);
    checks++;
    if (start0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL zero_start: start=%b busy=%b expected 1 1", start0, busy0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (start0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL zero_run: start=%b busy=%b done=%b expected 0 1 0", start0, busy0, done0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b expected 1 0", done0, busy0);
    end
    checks++;
    if ({in_ready0, sel0, current_addr0, ar_in0, mem_data0, out_data0} !== 67'h0) begin
      errors++; $display("FAIL zero_outputs: got %h expected 0",
                         {in_ready0, sel0, current_addr0, ar_in0, mem_data0, out_data0});
    end
    @(posedge clk); #1;
    checks++;
    if (bad0 !== b) begin
      errors++; $display("FAIL zero_no_traffic: got %0d write/valid cycles expected 0", bad0 - b);
    end
    in_valid0 = 0;
  endtask

  initial begin
    test_reset();
    end_in = 1;
    test_load();
    test_run(1'b1);
    test_dump(1'b1);
    test_load();
    test_run(1'b0);
    test_dump(1'b0);
    test_reset_mid_load();
    test_load();
    test_run(1'b0);
    test_dump(1'b0);
    test_zero_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
